// File: rtl/shp_apply_if.sv
// Pixel/amount bus for the sharpening apply stage: taps, amount, blanking and stall in; sharpened pixel out.
interface shp_apply_if #(
    parameter int DW    = 12,
    parameter int AMT_W = 12
);
    logic             i_hs;
    logic             i_vs;
    logic             shp_en;
    logic [DW-1:0]    i_pix_c;
    logic [DW-1:0]    i_pix_l;
    logic [DW-1:0]    i_pix_r;
    logic [AMT_W-1:0] amout;
    logic [DW-1:0]    o_pix;
    logic             o_vld;

    modport master (
        output i_hs, i_vs, shp_en, i_pix_c, i_pix_l, i_pix_r, amout,
        input  o_pix, o_vld
    );

    modport slave (
        input  i_hs, i_vs, shp_en, i_pix_c, i_pix_l, i_pix_r, amout,
        output o_pix, o_vld
    );
endinterface

// File: rtl/shp_apply.sv
// Sharpening apply: out = clamp(c + round(amount * (2c - l - r))), taps delayed to meet the amount.
// Optional coring of small high-pass values is enabled with `define SHP_APPLY_CORING_EN.
module shp_apply #(
    parameter int DW        = 12,
    parameter int AMT_W     = 12,
    parameter int ALIGN_DLY = 4,
    parameter int CORE_TH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    shp_apply_if.slave bus
);
    localparam int HW   = DW + 2;
    localparam int PW   = HW + AMT_W;
    localparam int RW   = PW - 9;
    localparam int SW   = RW + 1;
    localparam int FILL = ALIGN_DLY + 3;
    localparam int CW   = $clog2(FILL + 1);

    logic flush;
    logic adv;

    logic [3*DW-1:0]         dl_q [ALIGN_DLY];
    logic [DW-1:0]           tap_c, tap_l, tap_r;

    logic signed [HW-1:0]    hp_d, hp1_q;
    logic [DW-1:0]           c1_q, c2_q;
    logic [AMT_W-1:0]        amt1_q;
    logic signed [PW-1:0]    prod;
    logic signed [PW:0]      rsum;
    logic signed [RW-1:0]    rnd_d, rnd_q;
    logic signed [SW-1:0]    sum;
    logic [DW-1:0]           pix_d, pix_q;
    logic [CW-1:0]           cnt_d, cnt_q;
    logic                    vld_q;

    // Blanking is treated exactly like reset so every line restarts from an empty pipeline.
    assign flush = rst || !bus.i_hs || !bus.i_vs;
    assign adv   = bus.shp_en;

    assign {tap_c, tap_l, tap_r} = dl_q[ALIGN_DLY-1];

    always_comb begin
        hp_d = $signed({1'b0, tap_c, 1'b0}) - $signed({2'b00, tap_l}) - $signed({2'b00, tap_r});
`ifdef SHP_APPLY_CORING_EN
        begin
            logic [HW-1:0] hp_abs;
            hp_abs = hp_d[HW-1] ? HW'(-hp_d) : HW'(hp_d);
            if (hp_abs < HW'(CORE_TH)) begin
                hp_d = '0;
            end
        end
`endif
    end

    always_comb begin
        prod  = hp1_q * $signed({1'b0, amt1_q});
        rsum  = $signed({prod[PW-1], prod}) + $signed((PW+1)'(512));
        rnd_d = rsum[PW:10];
    end

    always_comb begin
        sum = $signed({{(SW-DW){1'b0}}, c2_q}) + $signed({rnd_q[RW-1], rnd_q});
        if (sum[SW-1]) begin
            pix_d = '0;
        end else if (|sum[SW-2:DW]) begin
            pix_d = '1;
        end else begin
            pix_d = sum[DW-1:0];
        end
    end

    always_comb begin
        cnt_d = (cnt_q == CW'(FILL)) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int unsigned i = 0; i < ALIGN_DLY; i++) begin
                dl_q[i] <= '0;
            end
            hp1_q  <= '0;
            c1_q   <= '0;
            amt1_q <= '0;
            rnd_q  <= '0;
            c2_q   <= '0;
            pix_q  <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else if (adv) begin
            dl_q[0] <= {bus.i_pix_c, bus.i_pix_l, bus.i_pix_r};
            for (int unsigned i = 1; i < ALIGN_DLY; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
            hp1_q  <= hp_d;
            c1_q   <= tap_c;
            amt1_q <= bus.amout;
            rnd_q  <= rnd_d;
            c2_q   <= c1_q;
            pix_q  <= pix_d;
            cnt_q  <= cnt_d;
            vld_q  <= (cnt_d == CW'(FILL));
        end
    end

    assign bus.o_pix = pix_q;
    assign bus.o_vld = vld_q;
endmodule
